// File: rtl/fmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fmem_port_arbiter
//  Description : Shares one single-port synchronous frame SRAM between the
//                display read path (absolute priority) and the frame write
//                path (buffered in a small FIFO, drained in read-free cycles).
//                Optional feature macro FMEM_RAW_BYPASS_EN: reads that hit a
//                pending FIFO write return the youngest buffered data.
//  Revision    : 1.0  initial release
// ============================================================================
module fmem_port_arbiter #(
  parameter int MEM_WIDTH   = 96,
  parameter int ADDR_WIDTH  = 16,
  parameter int WFIFO_DEPTH = 4,
  parameter int LVL_WIDTH   = $clog2(WFIFO_DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  rst_n,
  input  logic                  i_wen,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [MEM_WIDTH-1:0]  i_wdata,
  output logic                  o_wfull,
  output logic [LVL_WIDTH-1:0]  o_wfifo_level,
  output logic                  o_wovf,
  input  logic                  i_wovf_clr,
  input  logic                  i_rreq,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic                  o_rvalid,
  output logic [MEM_WIDTH-1:0]  o_rdata,
  output logic                  o_mem_cs_n,
  output logic                  o_mem_we_n,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [MEM_WIDTH-1:0]  o_mem_wdata,
  input  logic [MEM_WIDTH-1:0]  i_mem_rdata
);

  localparam int                   c_PTR_W     = $clog2(WFIFO_DEPTH);
  localparam logic [LVL_WIDTH-1:0] c_DEPTH_LVL = LVL_WIDTH'(WFIFO_DEPTH);

  // Encoding chosen so bit1 is the SRAM chip select and bit0 the write
  // enable: the memory strobes come straight off flops, glitch free.
  typedef enum logic [1:0] {
    G_WR   = 2'b00,
    G_RD   = 2'b01,
    G_IDLE = 2'b11
  } grant_t;

  grant_t                r_gstate;
  grant_t                w_gnext;
  logic [LVL_WIDTH-1:0]  r_count;
  logic [c_PTR_W-1:0]    r_wptr;
  logic [c_PTR_W-1:0]    r_rptr;
  logic [ADDR_WIDTH-1:0] r_fifo_addr [WFIFO_DEPTH];
  logic [MEM_WIDTH-1:0]  r_fifo_data [WFIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [MEM_WIDTH-1:0]  r_mem_wdata;
  logic [2:0]            r_rv_pipe;
  logic [MEM_WIDTH-1:0]  r_rdata;
  logic                  r_wovf;
  logic [MEM_WIDTH-1:0]  w_rdata_src;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_drop;

  assign w_full = (r_count == c_DEPTH_LVL);
  assign w_push = i_wen & ~w_full;
  assign w_drop = i_wen & w_full;
  assign w_pop  = (w_gnext == G_WR);

  // Grant decision: reads always win, otherwise drain a buffered write
  always_comb begin
    w_gnext = G_IDLE;
    if (i_rreq) begin
      w_gnext = G_RD;
    end else if (r_count != '0) begin
      w_gnext = G_WR;
    end
  end

  // Grant state register; its encoding directly drives cs_n / we_n
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) r_gstate <= G_IDLE;
    else        r_gstate <= w_gnext;
  end

  // Memory address/data register; holds the last command while idle
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_gnext == G_RD) begin
      r_mem_addr  <= i_raddr;
    end else if (w_gnext == G_WR) begin
      r_mem_addr  <= r_fifo_addr[r_rptr];
      r_mem_wdata <= r_fifo_data[r_rptr];
    end
  end

  // Write buffer storage; contents are qualified by the count, so no reset
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= i_waddr;
      r_fifo_data[r_wptr] <= i_wdata;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (depth is 2^n)
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag; a new drop beats a simultaneous clear
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n)          r_wovf <= 1'b0;
    else if (w_drop)     r_wovf <= 1'b1;
    else if (i_wovf_clr) r_wovf <= 1'b0;
  end

  // Read valid pipeline: command cycle, SRAM data cycle, output cycle
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) r_rv_pipe <= '0;
    else        r_rv_pipe <= {r_rv_pipe[1:0], i_rreq};
  end

`ifdef FMEM_RAW_BYPASS_EN
  logic                 w_byp_hit;
  logic [MEM_WIDTH-1:0] w_byp_data;
  logic [1:0]           r_byp_hit;
  logic [MEM_WIDTH-1:0] r_byp_d0;
  logic [MEM_WIDTH-1:0] r_byp_d1;

  // Scan oldest to youngest so the youngest matching entry wins
  always_comb begin
    w_byp_hit  = 1'b0;
    w_byp_data = '0;
    for (int j = 0; j < WFIFO_DEPTH; j++) begin
      if ((LVL_WIDTH'(j) < r_count) &&
          (r_fifo_addr[r_rptr + c_PTR_W'(j)] == i_raddr)) begin
        w_byp_hit  = 1'b1;
        w_byp_data = r_fifo_data[r_rptr + c_PTR_W'(j)];
      end
    end
  end

  // Carry bypass hit/data alongside the read through the memory latency
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byp_hit <= '0;
      r_byp_d0  <= '0;
      r_byp_d1  <= '0;
    end else begin
      r_byp_hit <= {r_byp_hit[0], w_byp_hit & i_rreq};
      r_byp_d0  <= w_byp_data;
      r_byp_d1  <= r_byp_d0;
    end
  end

  assign w_rdata_src = r_byp_hit[1] ? r_byp_d1 : i_mem_rdata;
`else
  assign w_rdata_src = i_mem_rdata;
`endif

  // Output read data register; holds while no read completes
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n)            r_rdata <= '0;
    else if (r_rv_pipe[1]) r_rdata <= w_rdata_src;
  end

  assign o_mem_cs_n    = r_gstate[1];
  assign o_mem_we_n    = r_gstate[0];
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wdata   = r_mem_wdata;
  assign o_rvalid      = r_rv_pipe[2];
  assign o_rdata       = r_rdata;
  assign o_wfull       = w_full;
  assign o_wfifo_level = r_count;
  assign o_wovf        = r_wovf;

endmodule
`default_nettype wire

// File: tb/tb_fmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fmem_port_arbiter
//  Description : Directed self-checking bench for fmem_port_arbiter with a
//                behavioural single-port synchronous SRAM model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fmem_port_arbiter;

  logic        i_clk = 1'b0;
  logic        rst_n;
  logic        i_wen;
  logic [15:0] i_waddr;
  logic [95:0] i_wdata;
  logic        o_wfull;
  logic [2:0]  o_wfifo_level;
  logic        o_wovf;
  logic        i_wovf_clr;
  logic        i_rreq;
  logic [15:0] i_raddr;
  logic        o_rvalid;
  logic [95:0] o_rdata;
  logic        o_mem_cs_n;
  logic        o_mem_we_n;
  logic [15:0] o_mem_addr;
  logic [95:0] o_mem_wdata;
  logic [95:0] i_mem_rdata;

  logic [95:0] mem [0:65535];
  logic        pl_en;
  logic [15:0] pl_addr;
  logic [95:0] pl_data;

  int total = 0;
  int bad   = 0;

  localparam logic [95:0] c_OLD = 96'h0000_0000_0000_0000_DEAD_BEEF;
  localparam logic [95:0] c_NEW = 96'h0000_0000_0000_0000_CAFE_F00D;

  fmem_port_arbiter dut (
    .i_clk         (i_clk),
    .rst_n         (rst_n),
    .i_wen         (i_wen),
    .i_waddr       (i_waddr),
    .i_wdata       (i_wdata),
    .o_wfull       (o_wfull),
    .o_wfifo_level (o_wfifo_level),
    .o_wovf        (o_wovf),
    .i_wovf_clr    (i_wovf_clr),
    .i_rreq        (i_rreq),
    .i_raddr       (i_raddr),
    .o_rvalid      (o_rvalid),
    .o_rdata       (o_rdata),
    .o_mem_cs_n    (o_mem_cs_n),
    .o_mem_we_n    (o_mem_we_n),
    .o_mem_addr    (o_mem_addr),
    .o_mem_wdata   (o_mem_wdata),
    .i_mem_rdata   (i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  // Single-port synchronous SRAM: read data valid the cycle after the command
  always @(posedge i_clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (!o_mem_cs_n) begin
      if (!o_mem_we_n) mem[o_mem_addr] <= o_mem_wdata;
      else             i_mem_rdata     <= mem[o_mem_addr];
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; i_wen = 1'b0; i_waddr = '0; i_wdata = '0; i_wovf_clr = 1'b0;
    i_rreq = 1'b0; i_raddr = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    tick();
    pl_en = 1'b1; pl_addr = 16'h0003; pl_data = 96'h1234;
    tick();
    pl_addr = 16'h0020; pl_data = c_OLD;
    tick();
    pl_en = 1'b0;

    // ---- reset state
    chk("rst_cs_n",  o_mem_cs_n, 1);
    chk("rst_we_n",  o_mem_we_n, 1);
    chk("rst_addr",  o_mem_addr, 0);
    chk("rst_wdata", o_mem_wdata, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_rvalid", o_rvalid, 0);
    chk("rst_level", o_wfifo_level, 0);
    chk("rst_wfull", o_wfull, 0);
    chk("rst_wovf",  o_wovf, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_cs_n", o_mem_cs_n, 1);

    // ---- single write
    i_wen = 1'b1; i_waddr = 16'h0010; i_wdata = {12{8'hA5}};
    tick();
    i_wen = 1'b0;
    chk("wr_level1", o_wfifo_level, 1);
    chk("wr_cs_idle", o_mem_cs_n, 1);
    tick();
    chk("wr_cs_n",  o_mem_cs_n, 0);
    chk("wr_we_n",  o_mem_we_n, 0);
    chk("wr_addr",  o_mem_addr, 16'h0010);
    chk("wr_wdata", o_mem_wdata, {12{8'hA5}});
    chk("wr_level0", o_wfifo_level, 0);
    tick();
    chk("wr_done_cs", o_mem_cs_n, 1);
    chk("wr_hold_addr", o_mem_addr, 16'h0010);

    // ---- single read, 3-cycle latency
    i_rreq = 1'b1; i_raddr = 16'h0003;
    tick();
    i_rreq = 1'b0;
    chk("rd_cs_n", o_mem_cs_n, 0);
    chk("rd_we_n", o_mem_we_n, 1);
    chk("rd_addr", o_mem_addr, 16'h0003);
    chk("rd_rv_1", o_rvalid, 0);
    tick();
    chk("rd_rv_2", o_rvalid, 0);
    tick();
    chk("rd_rvalid", o_rvalid, 1);
    chk("rd_rdata", o_rdata, 96'h1234);
    tick();
    chk("rd_rv_end", o_rvalid, 0);
    chk("rd_hold", o_rdata, 96'h1234);

    // ---- contention: reads for 10 cycles, 6 writes pushed
    i_rreq = 1'b1; i_raddr = 16'h0005;
    for (int i = 0; i < 6; i++) begin
      i_wen = 1'b1; i_waddr = 16'(16'h0040 + i); i_wdata = 96'(i + 1);
      tick();
      if (i == 3) chk("ct_full_at4", o_wfull, 1);
    end
    i_wen = 1'b0;
    chk("ct_level", o_wfifo_level, 4);
    chk("ct_wovf", o_wovf, 1);
    for (int i = 0; i < 4; i++) tick();
    chk("ct_we_n_rd", o_mem_we_n, 1);
    chk("ct_level_held", o_wfifo_level, 4);
    chk("ct_rvalid_b2b", o_rvalid, 1);
    i_rreq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ct_drain_we", o_mem_we_n, 0);
      chk("ct_drain_addr", o_mem_addr, 16'h0040 + i);
      chk("ct_drain_data", o_mem_wdata, i + 1);
    end
    tick();
    chk("ct_idle", o_mem_cs_n, 1);
    chk("ct_empty", o_wfifo_level, 0);
    chk("ct_wovf_sticky", o_wovf, 1);
    i_wovf_clr = 1'b1;
    tick();
    i_wovf_clr = 1'b0;
    chk("ovf_clr", o_wovf, 0);

    // ---- interleave: read every other cycle, writes in the gaps
    for (int i = 0; i < 6; i++) begin
      i_rreq = 1'b1; i_wen = 1'b0;
      tick();
      chk("il_rd_we", o_mem_we_n, 1);
      chk("il_lvl_a", o_wfifo_level <= 1, 1);
      i_rreq = 1'b0; i_wen = 1'b1; i_waddr = 16'(16'h0080 + i); i_wdata = 96'(i + 16);
      tick();
      if (i > 0) begin
        chk("il_wr_we", o_mem_we_n, 0);
        chk("il_wr_addr", o_mem_addr, 16'h0080 + i - 1);
      end
      chk("il_lvl_b", o_wfifo_level, 1);
    end
    i_wen = 1'b0;
    tick();
    chk("il_last_addr", o_mem_addr, 16'h0085);
    chk("il_last_lvl", o_wfifo_level, 0);
    chk("il_wovf", o_wovf, 0);

    // ---- read-after-write hazard on address 0x20
    i_rreq = 1'b1; i_raddr = 16'h0000;
    i_wen = 1'b1; i_waddr = 16'h0020; i_wdata = c_NEW;
    tick();
    i_wen = 1'b0; i_raddr = 16'h0020;
    tick();
    i_rreq = 1'b0;
    chk("byp_pending", o_wfifo_level, 1);
    tick();
    chk("byp_wr_addr", o_mem_addr, 16'h0020);
    chk("byp_wr_we", o_mem_we_n, 0);
    tick();
    chk("byp_rvalid", o_rvalid, 1);
`ifdef FMEM_RAW_BYPASS_EN
    chk("byp_rdata", o_rdata, c_NEW);
`else
    chk("byp_rdata", o_rdata, c_OLD);
`endif
    tick();

    // ---- reset asserted mid-traffic
    i_rreq = 1'b1; i_raddr = 16'h0003;
    for (int i = 0; i < 6; i++) begin
      i_wen = 1'b1; i_waddr = 16'(16'h0100 + i); i_wdata = 96'(i);
      tick();
    end
    chk("mr_pre_wovf", o_wovf, 1);
    chk("mr_pre_rv", o_rvalid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr_cs_n", o_mem_cs_n, 1);
    chk("mr_we_n", o_mem_we_n, 1);
    chk("mr_rvalid", o_rvalid, 0);
    chk("mr_level", o_wfifo_level, 0);
    chk("mr_wovf", o_wovf, 0);
    i_rreq = 1'b0; i_wen = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mr_post_cs", o_mem_cs_n, 1);
      chk("mr_post_rv", o_rvalid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
